// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C byte-transaction engine between
// N_CLIENTS requesters, with a per-transaction timeout and sticky error flag.
module i2c_bus_arbiter #(
  parameter int N_CLIENTS      = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CLIENTS-1:0]   req,
  input  logic [N_CLIENTS-1:0]   req_we,
  input  logic [8*N_CLIENTS-1:0] req_addr,
  input  logic [8*N_CLIENTS-1:0] req_wdata,
  output logic [N_CLIENTS-1:0]   gnt,
  output logic [N_CLIENTS-1:0]   rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_ok,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   i2c_start,
  output logic                   i2c_re,
  output logic                   i2c_we,
  output logic [7:0]             i2c_addr,
  output logic [7:0]             i2c_wdata,
  input  logic [7:0]             i2c_rdata,
  input  logic                   i2c_done,
  input  logic                   i2c_we_success
);

  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     win_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [N_CLIENTS-1:0] gnt_q;
  logic [N_CLIENTS-1:0] rsp_valid_q;
  logic [7:0]           rsp_data_q;
  logic                 rsp_ok_q;
  logic                 terr_q;
  logic                 start_q;
  logic                 re_q;
  logic                 we_q;
  logic [7:0]           addr_q;
  logic [7:0]           wdata_q;

  logic                 any_req_d;
  logic [PTR_W-1:0]     win_d;
  logic [PTR_W:0]       sum_d;
  logic                 sel_we_d;
  logic [7:0]           sel_addr_d;
  logic [7:0]           sel_wdata_d;
  logic [PTR_W-1:0]     ptr_d;

  // Scan downwards so the set bit closest to ptr (lowest offset) is the last to win.
  always_comb begin
    any_req_d = 1'b0;
    win_d     = ptr_q;
    sum_d     = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      sum_d = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (sum_d >= (PTR_W + 1)'(N_CLIENTS)) begin
        sum_d = sum_d - (PTR_W + 1)'(N_CLIENTS);
      end
      if (req[sum_d[PTR_W-1:0]]) begin
        any_req_d = 1'b1;
        win_d     = sum_d[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_we_d    = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (win_d == PTR_W'(k)) begin
        sel_we_d    = req_we[k];
        sel_addr_d  = req_addr[8*k +: 8];
        sel_wdata_d = req_wdata[8*k +: 8];
      end
    end
  end

  assign ptr_d = (win_q == PTR_W'(N_CLIENTS - 1)) ? '0 : win_q + PTR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ok_q    <= 1'b0;
      terr_q      <= 1'b0;
      start_q     <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            win_q   <= win_d;
            gnt_q   <= N_CLIENTS'(1) << win_d;
            start_q <= 1'b1;
            we_q    <= sel_we_d;
            re_q    <= ~sel_we_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Completion takes priority over a timeout landing in the same cycle.
          if (i2c_done) begin
            rsp_data_q  <= we_q ? 8'h00 : i2c_rdata;
            rsp_ok_q    <= we_q ? i2c_we_success : 1'b1;
            rsp_valid_q <= N_CLIENTS'(1) << win_q;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            state_q     <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q  <= 8'h00;
            rsp_ok_q    <= 1'b0;
            terr_q      <= 1'b1;
            rsp_valid_q <= N_CLIENTS'(1) << win_q;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_ok      = rsp_ok_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
  assign i2c_start   = start_q;
  assign i2c_re      = re_q;
  assign i2c_we      = we_q;
  assign i2c_addr    = addr_q;
  assign i2c_wdata   = wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: two clients, short timeout, a small
// engine model that answers each launch after a per-transaction delay.
module tb_i2c_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_we;
  logic [8*N-1:0] req_addr, req_wdata;
  logic [N-1:0]   gnt, rsp_valid;
  logic [7:0]     rsp_data;
  logic           rsp_ok, busy, timeout_err;
  logic           i2c_start, i2c_re, i2c_we;
  logic [7:0]     i2c_addr, i2c_wdata, i2c_rdata;
  logic           i2c_done, i2c_we_success;

  typedef struct {
    int       client;
    bit       we;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] rdata;
    bit       succ;
    int       delay;
    bit [7:0] exp_data;
    bit       exp_ok;
    bit       exp_terr;
    int       exp_lat;
  } txn_t;

  txn_t     exp_q[$];
  txn_t     eng_t;
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       gnt_cyc = 0;
  int       eng_cnt = 0;
  bit       eng_active = 1'b0;
  bit       terr_model = 1'b0;
  bit       hold_mode = 1'b0;
  int       grant_cnt = 0;
  int       hold_target = 0;
  bit [7:0] last_data = 8'h00;

  always #5 clock = ~clock;

  i2c_bus_arbiter #(.N_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ok(rsp_ok),
    .busy(busy), .timeout_err(timeout_err),
    .i2c_start(i2c_start), .i2c_re(i2c_re), .i2c_we(i2c_we),
    .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .i2c_done(i2c_done), .i2c_we_success(i2c_we_success)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  task automatic push_exp(input int client, input bit we, input bit [7:0] addr,
                          input bit [7:0] wdata, input bit [7:0] rdata,
                          input bit succ, input int delay);
    txn_t t;
    bit   to_hit;
    to_hit     = (delay < 1) || (delay > TO);
    t.client   = client;
    t.we       = we;
    t.addr     = addr;
    t.wdata    = wdata;
    t.rdata    = rdata;
    t.succ     = succ;
    t.delay    = delay;
    t.exp_ok   = to_hit ? 1'b0 : (we ? succ : 1'b1);
    t.exp_data = (to_hit || we) ? 8'h00 : rdata;
    terr_model = terr_model | to_hit;
    t.exp_terr = terr_model;
    t.exp_lat  = to_hit ? TO + 1 : delay + 1;
    exp_q.push_back(t);
  endtask

  task automatic drive_req(input int client, input bit we, input bit [7:0] addr,
                           input bit [7:0] wdata);
    req[client]              = 1'b1;
    req_we[client]           = we;
    req_addr[8*client +: 8]  = addr;
    req_wdata[8*client +: 8] = wdata;
  endtask

  task automatic post(input int client, input bit we, input bit [7:0] addr,
                      input bit [7:0] wdata, input bit [7:0] rdata,
                      input bit succ, input int delay);
    drive_req(client, we, addr, wdata);
    push_exp(client, we, addr, wdata, rdata, succ, delay);
  endtask

  // One clock: engine model, response scoreboard, grant checks, req release.
  task automatic step();
    txn_t t;
    @(negedge clock);
    cyc++;
    i2c_done = 1'b0;
    if (eng_active) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        i2c_done       = 1'b1;
        i2c_rdata      = eng_t.rdata;
        i2c_we_success = eng_t.succ;
        eng_active     = 1'b0;
      end
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        t = exp_q.pop_front();
        check("rsp_valid", rsp_valid, onehot(t.client));
        check("rsp_data", rsp_data, t.exp_data);
        check("rsp_ok", rsp_ok, t.exp_ok);
        check("timeout_err", timeout_err, t.exp_terr);
        check("rsp_latency", cyc - gnt_cyc, t.exp_lat);
        last_data = t.exp_data;
      end
    end
    if (gnt != '0) begin
      check("gnt_bits", $countones(gnt), 1);
      check("busy_at_gnt", busy, 1);
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", gnt, 0);
      end else begin
        t = exp_q[0];
        check("gnt_client", gnt, onehot(t.client));
        check("i2c_start", i2c_start, 1);
        check("i2c_re", i2c_re, !t.we);
        check("i2c_we", i2c_we, t.we);
        check("i2c_addr", i2c_addr, t.addr);
        check("i2c_wdata", i2c_wdata, t.we ? t.wdata : req_wdata[8*t.client +: 8]);
        gnt_cyc    = cyc;
        eng_t      = t;
        eng_cnt    = t.delay;
        eng_active = (t.delay > 0);
        grant_cnt++;
        if (hold_mode) begin
          if (grant_cnt >= hold_target) begin
            req       = '0;
            hold_mode = 1'b0;
          end
        end else begin
          req[t.client] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || req != '0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      check("drain_budget", 1, 0);
      exp_q.delete();
      req        = '0;
      eng_active = 1'b0;
      hold_mode  = 1'b0;
    end
    step();
    check("idle_busy", busy, 0);
    check("rsp_hold", rsp_data, last_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    i2c_done = 1'b0; i2c_rdata = 8'h00; i2c_we_success = 1'b0;
    step();
    step();
    check("reset_outputs", {gnt, rsp_valid, rsp_data, rsp_ok, busy, timeout_err,
                            i2c_start, i2c_re, i2c_we, i2c_addr, i2c_wdata}, 0);
    reset = 1'b0;

    // Single read from client 0.
    post(0, 1'b0, 8'h3B, 8'h00, 8'hA5, 1'b1, 5);
    step();
    check("gnt_latency", gnt, 2'b01);
    drain(200);

    // Write NACK from client 1; engine rdata must not leak into rsp_data.
    post(1, 1'b1, 8'h6B, 8'h00, 8'h77, 1'b0, 4);
    drain(200);

    // Both clients hold req continuously for six transactions.
    hold_mode   = 1'b1;
    hold_target = grant_cnt + 6;
    for (int i = 0; i < 6; i++) begin
      post(i % 2, 1'b0, (i % 2) ? 8'h20 : 8'h10, 8'h00, 8'(8'h40 + i), 1'b1, 2 + i);
    end
    drain(500);

    // Done arrives on the exact timeout cycle.
    post(0, 1'b0, 8'h3B, 8'h00, 8'h12, 1'b1, TO);
    drain(200);
    check("terr_after_collision", timeout_err, 0);

    // Engine never answers.
    post(1, 1'b0, 8'h75, 8'h00, 8'h99, 1'b1, -1);
    drain(200);
    check("terr_sticky", timeout_err, 1);
    i2c_done       = 1'b1;
    i2c_rdata      = 8'hEE;
    i2c_we_success = 1'b1;
    repeat (4) step();
    check("stray_done_busy", busy, 0);
    check("stray_done_data", rsp_data, 8'h00);
    post(0, 1'b0, 8'h3B, 8'h00, 8'h5A, 1'b1, 3);
    drain(200);
    check("terr_still_set", timeout_err, 1);

    // Reset two cycles into WAIT with both clients pending.
    post(0, 1'b0, 8'h41, 8'h00, 8'h00, 1'b1, -1);
    g0 = grant_cnt;
    n  = 0;
    while (grant_cnt == g0 && n < 50) begin
      step();
      n++;
    end
    check("rst_test_granted", grant_cnt, g0 + 1);
    step();
    step();
    drive_req(0, 1'b1, 8'h50, 8'hC3);
    drive_req(1, 1'b0, 8'h51, 8'h00);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {gnt, rsp_valid, rsp_data, rsp_ok, busy, timeout_err,
                              i2c_start, i2c_re, i2c_we, i2c_addr, i2c_wdata}, 0);
    exp_q.delete();
    eng_active = 1'b0;
    terr_model = 1'b0;
    last_data  = 8'h00;
    push_exp(0, 1'b1, 8'h50, 8'hC3, 8'h00, 1'b1, 2);
    push_exp(1, 1'b0, 8'h51, 8'h00, 8'h3C, 1'b1, 2);
    step();
    step();
    reset = 1'b0;
    drain(300);
    check("terr_cleared", timeout_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C_Interface byte-transaction engine between several requesters, for example MPU_Controller and a register-init sequencer.
- Each requester posts a one-byte read or write. The arbiter picks one round-robin, launches it on the engine, and waits for done or timeout.
- It then returns the result to the winning requester only.
- It sits between the requester blocks and the I2C_Interface instance; scl/sda stay on the engine.

Parameters:
- N_CLIENTS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 100000, max cycles in WAIT before abandoning a transaction.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- req  in  N_CLIENTS  per-client request, held until gnt
- req_we  in  N_CLIENTS  per-client: 1=write, 0=read
- req_addr  in  8*N_CLIENTS  per-client register address, client k at [8k+7:8k]
- req_wdata  in  8*N_CLIENTS  per-client write byte, same packing
- gnt  out  N_CLIENTS  one-cycle pulse, request accepted
- rsp_valid  out  N_CLIENTS  one-cycle pulse, transaction finished
- rsp_data  out  8  read byte, valid with rsp_valid
- rsp_ok  out  1  success flag, valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky, set on any timeout, cleared only by reset
- i2c_start  out  1  one-cycle launch pulse to engine
- i2c_re  out  1  read enable, held ISSUE..WAIT
- i2c_we  out  1  write enable, held ISSUE..WAIT
- i2c_addr  out  8  register address to engine, held ISSUE..WAIT
- i2c_wdata  out  8  write byte to engine, held ISSUE..WAIT
- i2c_rdata  in  8  read byte from engine, valid with i2c_done
- i2c_done  in  1  engine completion pulse
- i2c_we_success  in  1  write ACKed, valid with i2c_done

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, ptr=0, counter=0.
  - All outputs 0, including timeout_err and i2c_start.
  - Reset mid-transaction aborts immediately. No gnt or rsp_valid is emitted for the aborted request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, winner w = first set bit at index ptr, ptr+1, ... mod N_CLIENTS.
  - Register w plus req_we[w], req_addr[w], req_wdata[w].
  - Next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt[w]=1 and i2c_start=1.
  - i2c_re=~we_lat, i2c_we=we_lat; addr/wdata driven from the latched fields.
  - Counter cleared. Next state is WAIT.
- WAIT:
  - i2c_re, i2c_we, i2c_addr and i2c_wdata stay held; the counter increments every cycle.
  - On i2c_done, capture rsp_data = we_lat ? 0 : i2c_rdata and rsp_ok = we_lat ? i2c_we_success : 1. Go to RESP.
  - Else, when counter == TIMEOUT_CYCLES-1, rsp_data=0, rsp_ok=0, timeout_err=1. Go to RESP.
  - i2c_done wins over timeout in the same cycle.
- RESP (exactly 1 cycle):
  - rsp_valid[w]=1 with the captured data and flag.
  - ptr = (w+1) mod N_CLIENTS. Next state is IDLE.
- Fixed latency:
  - Request sampled in IDLE at cycle t: gnt at t+1.
  - Done seen at cycle d: rsp_valid at d+1.
  - Minimum turnaround is 4 cycles, since an i2c_done in the first WAIT cycle is legal.
- Requester contract:
  - Fields are sampled only in the IDLE cycle that selects the requester. They may change after gnt.
  - Dropping req before gnt withdraws the request with no side effect.
- Strays and overlaps:
  - i2c_done outside WAIT, e.g. late after a timeout, is ignored.
  - A req from the current winner during ISSUE/WAIT/RESP is a new request, arbitrated at the next IDLE.
- Outputs:
  - gnt and rsp_valid are one-hot or zero, never multi-bit.
  - rsp_data and rsp_ok hold their last value outside RESP.

Test Plan:
- Single read: client0 read addr 0x3B. Engine returns done 5 cycles after start with rdata 0xA5 -> gnt[0] at t+1, i2c_re=1, i2c_addr=0x3B, rsp_valid[0] one cycle after done, rsp_data=0xA5, rsp_ok=1.
- Write NACK: client1 write addr 0x6B, data 0x00; engine done with we_success=0 -> i2c_we=1, i2c_wdata=0x00, rsp_valid[1], rsp_ok=0, rsp_data=0x00.
- Round-robin fairness: both clients hold req continuously for 6 transactions -> grant order 0,1,0,1,0,1; never two gnt bits in one cycle.
- Timeout: TIMEOUT_CYCLES=16, engine never signals done -> rsp_valid 17 cycles after gnt with rsp_ok=0 and timeout_err=1 sticky. A late i2c_done in IDLE is ignored, and the next request completes normally.
- Done/timeout collision: i2c_done asserted on the exact timeout cycle with rdata 0x12 -> rsp_ok=1, rsp_data=0x12, timeout_err stays 0.
- Reset mid-WAIT: assert reset two cycles after i2c_start -> all outputs 0 at once, ptr=0, no rsp_valid. After release, client1's pending req is granted before client0 only if client0 is idle.
